stage_scheduler: RTL and testbench

STAGE_SCHEDULER -- requirements
Module: stage_scheduler

---
 rtl/img_pkg.sv | 38 +++
 rtl/scan_addr_gen.sv | 64 ++++++
 rtl/stage_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_stage_scheduler.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared image-pipeline constants, stage and scheduler encodings, and the
// row-major pixel address helper for the 20x20 image register file.
package img_pkg;

  localparam int IMG_DIM       = 20;
  localparam int BIT_LENGTH    = 5;
  localparam int ADDR_W        = 9;
  localparam int K_SMALL       = 3;
  localparam int K_LARGE       = 5;
  localparam int K_MAX         = K_LARGE;
  localparam int DRAIN_TIMEOUT = 8;
  localparam int IDLE_W        = $clog2(DRAIN_TIMEOUT);

  typedef enum logic [2:0] {
    STG_IDLE    = 3'd0,
    STG_MED     = 3'd1,
    STG_GAU     = 3'd2,
    STG_SOBEL   = 3'd3,
    STG_NON_MAX = 3'd4,
    STG_HYSTER  = 3'd5
  } stage_e;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SET_OP     = 3'd1,
    S_ROW_START  = 3'd2,
    S_FEED       = 3'd3,
    S_DRAIN      = 3'd4,
    S_WRITE_BACK = 3'd5,
    S_DONE       = 3'd6
  } sched_state_e;

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [BIT_LENGTH-1:0] row,
                                                 input logic [BIT_LENGTH-1:0] col);
    return ADDR_W'(row) * ADDR_W'(IMG_DIM) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/scan_addr_gen.sv
// Band row / column counters and the registered read addresses of one kernel
// column; lanes at or beyond the active kernel size read address 0.
module scan_addr_gen
  import img_pkg::*;
#(
  parameter int K = K_MAX
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr_r,
  input  logic                    clr_c,
  input  logic                    inc_c,
  input  logic                    inc_r,
  input  logic                    k_five,
  output logic [BIT_LENGTH-1:0]   r,
  output logic [BIT_LENGTH-1:0]   c,
  output logic [K*ADDR_W-1:0]     rd_addr_bus
);

  logic [BIT_LENGTH-1:0] r_reg;
  logic [BIT_LENGTH-1:0] c_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_reg <= '0;
      c_reg <= '0;
    end else begin
      if (clr_r)
        r_reg <= '0;
      else if (inc_r)
        r_reg <= r_reg + 1'b1;
      if (clr_c)
        c_reg <= '0;
      else if (inc_c)
        c_reg <= c_reg + 1'b1;
    end
  end

  assign r = r_reg;
  assign c = c_reg;

  genvar gi;
  generate
    for (gi = 0; gi < K; gi++) begin : g_lane
      logic              lane_on;
      logic [ADDR_W-1:0] addr_reg;

      // Lanes 0..2 serve every kernel; the last two only the 5x5 one.
      assign lane_on = k_five || (gi < K_SMALL);

      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          addr_reg <= '0;
        else if (inc_c && lane_on)
          addr_reg <= pix_addr(r_reg + BIT_LENGTH'(gi), c_reg);
        else
          addr_reg <= '0;
      end

      assign rd_addr_bus[gi*ADDR_W +: ADDR_W] = addr_reg;
    end
  endgenerate

endmodule

// File: rtl/stage_scheduler.sv
// Sequences the five filter stages over the image register file: feeds kernel
// columns band by band, collects sub-module outputs, then commands write-back.
module stage_scheduler
  import img_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                mod_readable,
  output logic [2:0]          stage,
  output logic [ADDR_W-1:0]   rd_addr0,
  output logic [ADDR_W-1:0]   rd_addr1,
  output logic [ADDR_W-1:0]   rd_addr2,
  output logic [ADDR_W-1:0]   rd_addr3,
  output logic [ADDR_W-1:0]   rd_addr4,
  output logic                feed_valid,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic                wb_pulse,
  output logic                border_w,
  output logic                busy,
  output logic                done,
  output logic                err
);

  sched_state_e state_reg, state_next;
  stage_e       stage_reg, stage_next;

  logic [BIT_LENGTH-1:0] o_reg;
  logic [IDLE_W-1:0]     idle_reg;
  logic                  feed_valid_reg;
  logic                  wb_pulse_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  err_reg;
  logic                  border_w_reg;

  logic clr_r, clr_c, inc_c, inc_r, o_clr, err_set, err_clr;

  logic [BIT_LENGTH-1:0]  r, c;
  logic [K_MAX*ADDR_W-1:0] rd_addr_bus;
  logic [BIT_LENGTH-1:0]  k_size, half, band_len, last_row;
  logic                   scanning, band_full, timeout;

  // border_w doubles as the "kernel is 5x5" flag for the current stage.
  assign k_size   = border_w_reg ? BIT_LENGTH'(K_LARGE) : BIT_LENGTH'(K_SMALL);
  assign half     = k_size >> 1;
  assign band_len = BIT_LENGTH'(IMG_DIM + 1) - k_size;
  assign last_row = BIT_LENGTH'(IMG_DIM) - k_size;

  assign scanning  = (state_reg == S_FEED) || (state_reg == S_DRAIN);
  assign band_full = (o_reg == band_len);
  assign timeout   = (state_reg == S_DRAIN) && !mod_readable &&
                     (idle_reg == IDLE_W'(DRAIN_TIMEOUT - 1));

  assign wr_en   = scanning && mod_readable && (o_reg < band_len);
  assign wr_addr = wr_en ? pix_addr(r + half, o_reg + half) : '0;

  scan_addr_gen #(.K(K_MAX)) u_scan (
    .clk         (clk),
    .reset       (reset),
    .clr_r       (clr_r),
    .clr_c       (clr_c),
    .inc_c       (inc_c),
    .inc_r       (inc_r),
    .k_five      (border_w_reg),
    .r           (r),
    .c           (c),
    .rd_addr_bus (rd_addr_bus)
  );

  always_comb begin
    state_next = state_reg;
    stage_next = stage_reg;
    clr_r      = 1'b0;
    clr_c      = 1'b0;
    inc_c      = 1'b0;
    inc_r      = 1'b0;
    o_clr      = 1'b0;
    err_set    = 1'b0;
    err_clr    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_SET_OP;
          err_clr    = 1'b1;
        end
      end
      S_SET_OP: begin
        stage_next = stage_e'(stage_reg + 3'd1);
        clr_r      = 1'b1;
        clr_c      = 1'b1;
        state_next = S_ROW_START;
      end
      S_ROW_START: begin
        clr_c      = 1'b1;
        o_clr      = 1'b1;
        state_next = S_FEED;
      end
      S_FEED: begin
        inc_c = 1'b1;
        if (c == BIT_LENGTH'(IMG_DIM - 1))
          state_next = S_DRAIN;
      end
      S_DRAIN: begin
        // A timeout closes the band exactly as a full band would.
        if (band_full || timeout) begin
          err_set = !band_full;
          if (r < last_row) begin
            inc_r      = 1'b1;
            state_next = S_ROW_START;
          end else if (stage_reg == STG_HYSTER) begin
            state_next = S_DONE;
          end else begin
            state_next = S_WRITE_BACK;
          end
        end
      end
      S_WRITE_BACK: state_next = S_SET_OP;
      S_DONE: begin
        stage_next = STG_IDLE;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      stage_reg      <= STG_IDLE;
      o_reg          <= '0;
      idle_reg       <= '0;
      feed_valid_reg <= 1'b0;
      wb_pulse_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
      border_w_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      stage_reg      <= stage_next;
      border_w_reg   <= (stage_next == STG_GAU);
      feed_valid_reg <= inc_c;
      wb_pulse_reg   <= (state_next == S_WRITE_BACK);
      done_reg       <= (state_next == S_DONE);
      busy_reg       <= (state_next != S_IDLE);

      if (o_clr)
        o_reg <= '0;
      else if (wr_en)
        o_reg <= o_reg + 1'b1;

      if ((state_reg != S_DRAIN) || mod_readable)
        idle_reg <= '0;
      else
        idle_reg <= idle_reg + 1'b1;

      if (err_clr)
        err_reg <= 1'b0;
      else if (err_set)
        err_reg <= 1'b1;
    end
  end

  assign stage      = stage_reg;
  assign feed_valid = feed_valid_reg;
  assign wb_pulse   = wb_pulse_reg;
  assign border_w   = border_w_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign err        = err_reg;

  assign rd_addr0 = rd_addr_bus[0*ADDR_W +: ADDR_W];
  assign rd_addr1 = rd_addr_bus[1*ADDR_W +: ADDR_W];
  assign rd_addr2 = rd_addr_bus[2*ADDR_W +: ADDR_W];
  assign rd_addr3 = rd_addr_bus[3*ADDR_W +: ADDR_W];
  assign rd_addr4 = rd_addr_bus[4*ADDR_W +: ADDR_W];

endmodule

// File: tb/tb_stage_scheduler.sv
// Bench for stage_scheduler: startup vector table, an event scoreboard of every
// write / write-back / done, and hand sequences for timeout and mid-run reset.
module tb_stage_scheduler;

  logic       clk;
  logic       reset;
  logic       start;
  logic       mod_readable;
  logic [2:0] stage;
  logic [8:0] rd_addr0, rd_addr1, rd_addr2, rd_addr3, rd_addr4;
  logic       feed_valid;
  logic       wr_en;
  logic [8:0] wr_addr;
  logic       wb_pulse;
  logic       border_w;
  logic       busy;
  logic       done;
  logic       err;

  stage_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .mod_readable (mod_readable),
    .stage        (stage),
    .rd_addr0     (rd_addr0),
    .rd_addr1     (rd_addr1),
    .rd_addr2     (rd_addr2),
    .rd_addr3     (rd_addr3),
    .rd_addr4     (rd_addr4),
    .feed_valid   (feed_valid),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wb_pulse     (wb_pulse),
    .border_w     (border_w),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] all_out;
  assign all_out = {stage, rd_addr0, rd_addr1, rd_addr2, rd_addr3, rd_addr4,
                    feed_valid, wr_en, wr_addr, wb_pulse, border_w, busy, done, err};

  typedef struct {
    logic       start;
    logic [2:0] stage;
    logic       busy;
    logic       fv;
    logic [8:0] a0, a1, a2, a3, a4;
  } vec_t;

  typedef struct {
    int kind;   // 0 write, 1 write-back, 2 done
    int val;
  } ev_t;

  ev_t  exp_q[$];
  vec_t tbl[6];
  int   n_vec = 0;
  int   n_fail = 0;
  int   wr_cnt = 0;
  int   wb_cnt = 0;
  bit   sb_en = 0;
  int   mode = 0;   // 0 delayed filter, 1 silent during MED, 2 always readable
  logic [3:0] pipe;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, expv);
    end else begin
      $display("chk %s = %0d", name, got);
    end
  endtask

  task automatic sb_check(input int kind, input int val);
    ev_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL sb_unexpected: got kind %0d value %0d, expected no event", kind, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val) begin
        n_fail++;
        $display("FAIL sb_event: got kind %0d value %0d, expected kind %0d value %0d",
                 kind, val, e.kind, e.val);
      end else begin
        $display("txn t=%0t kind %0d value %0d", $time, kind, val);
      end
    end
  endtask

  task automatic check_first_column();
    int          k;
    logic [44:0] got;
    logic [44:0] expv;
    k    = (stage == 3'd2) ? 5 : 3;
    got  = {rd_addr4, rd_addr3, rd_addr2, rd_addr1, rd_addr0};
    expv = '0;
    for (int n = 0; n < 5; n++)
      expv[n*9 +: 9] = (n < k) ? 9'(n * 20) : 9'd0;
    check($sformatf("first_col_stage%0d", stage), 64'(got), 64'(expv));
  endtask

  task automatic push_run(input bit silent_med);
    ev_t e;
    for (int st = 1; st <= 5; st++) begin
      int k;
      int h;
      k = (st == 2) ? 5 : 3;
      h = k / 2;
      if (!(silent_med && st == 1)) begin
        for (int r = 0; r <= 20 - k; r++) begin
          for (int o = 0; o <= 20 - k; o++) begin
            e.kind = 0;
            e.val  = (r + h) * 20 + o + h;
            exp_q.push_back(e);
          end
        end
      end
      if (st < 5) begin
        e.kind = 1;
        e.val  = (k == 5) ? 1 : 0;
        exp_q.push_back(e);
      end
    end
    e.kind = 2;
    e.val  = 0;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int budget, input bit poke);
    int n;
    bit seen;
    n    = 0;
    seen = 0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (done) begin
        seen = 1;
        break;
      end
      if (poke)
        start = ($urandom_range(0, 39) == 0);
    end
    start = 1'b0;
    check("done_within_budget", 64'(seen), 64'd1);
    @(negedge clk);
    check("post_done_busy", 64'(busy), 64'd0);
    check("post_done_stage", 64'(stage), 64'd0);
  endtask

  // Filter sub-module model: echoes each fed column a few cycles later.
  initial begin
    mod_readable = 1'b0;
    pipe         = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset)
        pipe = '0;
      else
        pipe = {pipe[2:0], feed_valid};
      case (mode)
        0:       mod_readable = pipe[3];
        1:       mod_readable = pipe[3] && (stage != 3'd1);
        default: mod_readable = 1'b1;
      endcase
    end
  end

  // Output monitor feeding the scoreboard.
  initial begin
    logic [2:0] last_stage;
    bit         fv_seen;
    last_stage = 3'd0;
    fv_seen    = 0;
    forever begin
      @(negedge clk);
      if (sb_en) begin
        if (stage != last_stage) begin
          last_stage = stage;
          fv_seen    = 0;
        end
        if (feed_valid && !fv_seen) begin
          fv_seen = 1;
          check_first_column();
        end
        if (wr_en) begin
          wr_cnt++;
          sb_check(0, int'(wr_addr));
        end
        if (wb_pulse) begin
          wb_cnt++;
          sb_check(1, int'(border_w));
        end
        if (done)
          sb_check(2, 0);
      end
    end
  end

  initial begin
    logic [63:0] got;
    logic [63:0] expv;
    int          n;
    int          rises;
    logic        pfv;

    tbl[0] = '{1'b1, 3'd0, 1'b1, 1'b0, 9'd0, 9'd0,  9'd0,  9'd0, 9'd0};
    tbl[1] = '{1'b0, 3'd1, 1'b1, 1'b0, 9'd0, 9'd0,  9'd0,  9'd0, 9'd0};
    tbl[2] = '{1'b1, 3'd1, 1'b1, 1'b0, 9'd0, 9'd0,  9'd0,  9'd0, 9'd0};
    tbl[3] = '{1'b0, 3'd1, 1'b1, 1'b1, 9'd0, 9'd20, 9'd40, 9'd0, 9'd0};
    tbl[4] = '{1'b0, 3'd1, 1'b1, 1'b1, 9'd1, 9'd21, 9'd41, 9'd0, 9'd0};
    tbl[5] = '{1'b1, 3'd1, 1'b1, 1'b1, 9'd2, 9'd22, 9'd42, 9'd0, 9'd0};

    reset = 1'b1;
    start = 1'b0;
    mode  = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_out, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Run A: normal sequence, startup latency table with starts while busy.
    wr_cnt = 0;
    wb_cnt = 0;
    exp_q.delete();
    push_run(0);
    sb_en = 1;
    for (int i = 0; i < 6; i++) begin
      start = tbl[i].start;
      @(negedge clk);
      got  = 64'({stage, busy, feed_valid, rd_addr0, rd_addr1, rd_addr2, rd_addr3, rd_addr4});
      expv = 64'({tbl[i].stage, tbl[i].busy, tbl[i].fv,
                  tbl[i].a0, tbl[i].a1, tbl[i].a2, tbl[i].a3, tbl[i].a4});
      check($sformatf("startup_vec%0d", i), got, expv);
    end
    start = 1'b0;
    wait_done(6000, 0);
    check("A_queue_left", 64'(exp_q.size()), 64'd0);
    check("A_wb_count", 64'(wb_cnt), 64'd4);
    check("A_wr_count", 64'(wr_cnt), 64'd1552);
    check("A_err", 64'(err), 64'd0);

    // Run B: no filter output during MED, every band times out.
    mode   = 1;
    wr_cnt = 0;
    wb_cnt = 0;
    push_run(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(8000, 0);
    check("B_err", 64'(err), 64'd1);
    check("B_queue_left", 64'(exp_q.size()), 64'd0);
    check("B_wb_count", 64'(wb_cnt), 64'd4);
    check("B_wr_count", 64'(wr_cnt), 64'd1228);

    // Run C: mod_readable stuck high, random starts while busy.
    mode   = 2;
    wr_cnt = 0;
    wb_cnt = 0;
    push_run(0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("C_err_cleared", 64'(err), 64'd0);
    wait_done(6000, 1);
    check("C_queue_left", 64'(exp_q.size()), 64'd0);
    check("C_wb_count", 64'(wb_cnt), 64'd4);
    check("C_wr_count", 64'(wr_cnt), 64'd1552);

    // Run D: reset during SOBEL band 5, then a clean restart.
    mode   = 0;
    wr_cnt = 0;
    wb_cnt = 0;
    push_run(0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (stage != 3'd3 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("D_reached_sobel", 64'(stage), 64'd3);
    rises = 0;
    pfv   = feed_valid;
    n     = 0;
    while (rises < 5 && n < 2000) begin
      @(negedge clk);
      n++;
      if (feed_valid && !pfv)
        rises++;
      pfv = feed_valid;
    end
    check("D_band5_found", 64'(rises), 64'd5);
    repeat (6) @(negedge clk);
    sb_en = 0;
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("D_reset_outputs", all_out, 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    wr_cnt = 0;
    wb_cnt = 0;
    push_run(0);
    sb_en = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("D_restart_stage", 64'(stage), 64'd1);
    repeat (2) @(negedge clk);
    check("D_restart_fv", 64'(feed_valid), 64'd1);
    check("D_restart_addr", 64'({rd_addr0, rd_addr1}), 64'({9'd0, 9'd20}));
    wait_done(6000, 0);
    check("D_queue_left", 64'(exp_q.size()), 64'd0);
    check("D_wr_count", 64'(wr_cnt), 64'd1552);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
